// File: rtl/fp_pkg.sv
// Shared fixed-point package: word types, saturating helpers and the synapse sweep state type.
package fp;

  localparam int WORD_LENGTH = 16;
  localparam int WW          = 2 * WORD_LENGTH;

  typedef logic signed [WORD_LENGTH-1:0] fpType;
  typedef logic signed [WW-1:0]          fpWideType;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    OUT   = 2'd2
  } synArrayState_t;

  localparam fpWideType WORD_MAX = fpWideType'((64'sd1 <<< (WORD_LENGTH - 1)) - 64'sd1);
  localparam fpWideType WORD_MIN = ~WORD_MAX;

  function automatic logic [WORD_LENGTH-1:0] sat_add_u(input logic [WORD_LENGTH-1:0] a,
                                                       input logic [WORD_LENGTH-1:0] b);
    logic [WORD_LENGTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[WORD_LENGTH]) return '1;
    else return s[WORD_LENGTH-1:0];
  endfunction

  // Signed add saturating to a 'width'-bit two's complement range (width <= WW)
  function automatic fpWideType sat_add_s(input fpWideType a, input fpWideType b, input int width);
    logic signed [WW:0] s;
    logic signed [WW:0] hi;
    logic signed [WW:0] lo;
    logic signed [WW:0] one;
    one = (WW + 1)'(1);
    s   = {a[WW-1], a} + {b[WW-1], b};
    hi  = (one <<< (width - 1)) - one;
    lo  = ~hi;
    if (s > hi) return hi[WW-1:0];
    else if (s < lo) return lo[WW-1:0];
    else return s[WW-1:0];
  endfunction

  function automatic fpType clamp_word(input fpWideType a);
    if (a > WORD_MAX) return WORD_MAX[WORD_LENGTH-1:0];
    else if (a < WORD_MIN) return WORD_MIN[WORD_LENGTH-1:0];
    else return a[WORD_LENGTH-1:0];
  endfunction

endpackage

// File: rtl/synapse_channel_alu.sv
// Combinational per-channel datapath: conductance decay, spike weight add and channel current.
// SYNAPSE_ARRAY_SAT_EN selects a saturating weight add; otherwise the add wraps.
module synapse_channel_alu
  import fp::*;
#(
  parameter int DECAY_SHIFT = 15,
  parameter int OUT_SHIFT   = 9
) (
  input  logic [WORD_LENGTH-1:0] gsyn,
  input  logic [WORD_LENGTH-1:0] tau_syn,
  input  logic [WORD_LENGTH-1:0] weight,
  input  logic                   pending,
  input  fpType                  e_rev,
  input  fpType                  vmem,
  output logic [WORD_LENGTH-1:0] gsyn_next,
  output fpWideType              current
);

  localparam int WL = WORD_LENGTH;
  localparam logic [WL-1:0] G_ONE = WL'(1);

  logic [2*WL-1:0]      decay_prod;
  logic [WL-1:0]        decay;
  logic [WL-1:0]        g_decayed;
  fpType                diff;
  logic signed [2*WL:0] diff_x;
  logic signed [2*WL:0] g_x;
  logic signed [2*WL:0] cur_prod;

  // A conductance that no longer decays is forced to zero so channels always go quiet
  always_comb begin
    decay_prod = {{WL{1'b0}}, gsyn} * {{WL{1'b0}}, tau_syn};
    decay      = WL'(decay_prod >> DECAY_SHIFT);
    if (gsyn == G_ONE || (gsyn != '0 && decay == '0)) g_decayed = '0;
    else g_decayed = gsyn - decay;

    if (pending) begin
`ifdef SYNAPSE_ARRAY_SAT_EN
      gsyn_next = sat_add_u(g_decayed, weight);
`else
      gsyn_next = g_decayed + weight;
`endif
    end else begin
      gsyn_next = g_decayed;
    end

    diff     = e_rev - vmem;
    diff_x   = (2*WL + 1)'(diff);
    g_x      = signed'({{(WL+1){1'b0}}, gsyn_next});
    cur_prod = diff_x * g_x;
    current  = fpWideType'(cur_prod >>> OUT_SHIFT);
  end

endmodule

// File: rtl/synapse_array.sv
// Time-multiplexed conductance synapse array with a word-serial config chain.
// SYNAPSE_ARRAY_SAT_EN enables saturation of gsyn add, accumulator and output; otherwise all wrap.
module synapse_array
  import fp::*;
#(
  parameter int N_SYN       = 4,
  parameter int DECAY_SHIFT = 15,
  parameter int OUT_SHIFT   = 9,
  parameter int ACC_WIDTH   = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [N_SYN-1:0] spike_in,
  input  fpType            vmem,
  output fpType            output_current,
  output logic             current_valid,
  output logic             busy,
  output logic             tick_overrun,
  input  logic             cfg_valid,
  input  fpType            cfg_data_in,
  output fpType            cfg_data_out,
  output logic             cfg_ready
);

  localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam int CHAIN = 3 * N_SYN;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SYN - 1);

  synArrayState_t              state;
  logic [IDX_W-1:0]            idx;
  logic [WORD_LENGTH-1:0]      gsyn [N_SYN];
  logic [N_SYN-1:0]            pending;
  logic [N_SYN-1:0]            clear_mask;
  fpType                       chain [CHAIN];
  fpType                       e_rev [N_SYN];
  logic [WORD_LENGTH-1:0]      weight [N_SYN];
  logic [WORD_LENGTH-1:0]      tau_syn [N_SYN];
  fpType                       vmem_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  fpType                       out_word;
  logic [WORD_LENGTH-1:0]      g_next;
  fpWideType                   cur;
  logic                        cfg_shift;

  assign cfg_ready    = !busy;
  assign cfg_shift    = cfg_valid && !busy;
  assign tick_overrun = tick && busy;

  // Channel 0 sits nearest cfg_data_in, ordered E_rev, weight, tau_syn
  for (genvar k = 0; k < N_SYN; k++) begin : g_cfg
    assign e_rev[k]   = chain[3*k];
    assign weight[k]  = chain[3*k+1];
    assign tau_syn[k] = chain[3*k+2];
  end

  // Config shift chain is deliberately left out of reset so settings survive it
  always_ff @(posedge clk) begin
    if (cfg_shift) begin
      chain[0] <= cfg_data_in;
      for (int k = CHAIN - 1; k > 0; k--) chain[k] <= chain[k-1];
      cfg_data_out <= chain[CHAIN-1];
    end
  end

  always_comb begin
    clear_mask = '0;
    if (state == SWEEP) clear_mask[idx] = 1'b1;
    else clear_mask = '0;
  end

  // Set beats clear so a spike landing on its own channel's slot waits for the next sweep
  always_ff @(posedge clk) begin
    if (!reset_n) pending <= '0;
    else pending <= (pending & ~clear_mask) | spike_in;
  end

  synapse_channel_alu #(
    .DECAY_SHIFT(DECAY_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_alu (
    .gsyn     (gsyn[idx]),
    .tau_syn  (tau_syn[idx]),
    .weight   (weight[idx]),
    .pending  (pending[idx]),
    .e_rev    (e_rev[idx]),
    .vmem     (vmem_q),
    .gsyn_next(g_next),
    .current  (cur)
  );

  always_comb begin
`ifdef SYNAPSE_ARRAY_SAT_EN
    acc_next = ACC_WIDTH'(sat_add_s(fpWideType'(acc), cur, ACC_WIDTH));
    out_word = clamp_word(fpWideType'(acc_next));
`else
    acc_next = ACC_WIDTH'(fpWideType'(acc) + cur);
    out_word = fpType'(acc_next[WORD_LENGTH-1:0]);
`endif
  end

  // The output is registered on the last channel's edge so it is visible during OUT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      vmem_q         <= '0;
      output_current <= '0;
      current_valid  <= 1'b0;
      busy           <= 1'b0;
      for (int k = 0; k < N_SYN; k++) gsyn[k] <= '0;
    end else begin
      current_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            vmem_q <= vmem;
            acc    <= '0;
            idx    <= '0;
            state  <= SWEEP;
            busy   <= 1'b1;
          end
        end
        SWEEP: begin
          gsyn[idx] <= g_next;
          acc       <= acc_next;
          if (idx == LAST) begin
            output_current <= out_word;
            current_valid  <= 1'b1;
            state          <= OUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        OUT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_array.sv
// Randomized self-checking bench for synapse_array against an arithmetic reference model.
module tb_synapse_array;
  import fp::*;

  localparam int N  = 4;
  localparam int DS = 15;
  localparam int OS = 9;
  localparam int AW = 24;
`ifdef SYNAPSE_ARRAY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n, tick, current_valid, busy, tick_overrun, cfg_valid, cfg_ready;
  logic [N-1:0] spike_in;
  fpType        vmem, output_current, cfg_data_in, cfg_data_out;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  synapse_array #(.N_SYN(N), .DECAY_SHIFT(DS), .OUT_SHIFT(OS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .spike_in(spike_in), .vmem(vmem),
    .output_current(output_current), .current_valid(current_valid), .busy(busy),
    .tick_overrun(tick_overrun), .cfg_valid(cfg_valid), .cfg_data_in(cfg_data_in),
    .cfg_data_out(cfg_data_out), .cfg_ready(cfg_ready)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0]  cq[$];
  longint       m_g[N];
  bit [N-1:0]   m_pend;
  int           m_phase = -1;
  longint       m_vq, m_acc;
  longint       m_out = 0;
  bit           m_valid = 1'b0, m_busy = 1'b0, m_cfg_known = 1'b0;
  longint       m_cfg_out;

  function automatic longint wrapn(input longint v, input int bits);
    longint m, x;
    m = longint'(1) << bits;
    x = v & (m - 1);
    if (x >= (m >> 1)) x -= m;
    return x;
  endfunction

  function automatic longint clampn(input longint v, input int bits);
    longint hi;
    hi = (longint'(1) << (bits - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic void model_channel(input int k, input bit pend);
    longint g, tau, w, e, dec, d;
    g   = m_g[k];
    e   = longint'(signed'(cq[3*k]));
    w   = longint'(cq[3*k+1]);
    tau = longint'(cq[3*k+2]);
    dec = ((g * tau) >> DS) % 65536;
    if (g == 1 || (g > 0 && dec == 0)) g = 0;
    else g = (g - dec + 65536) % 65536;
    if (pend) begin
      g = g + w;
      if (SAT) g = (g > 65535) ? 65535 : g;
      else g = g % 65536;
    end
    m_g[k] = g;
    d = wrapn(e - m_vq, 16);
    m_acc = m_acc + ((d * g) >>> OS);
    m_acc = SAT ? clampn(m_acc, AW) : wrapn(m_acc, AW);
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] pend_before;
    if (cfg_valid && !m_busy) begin
      cq.push_front(cfg_data_in);
      if (cq.size() > 3 * N) begin
        m_cfg_out   = longint'(signed'(cq.pop_back()));
        m_cfg_known = 1'b1;
      end
    end
    if (!reset_n) begin
      m_phase = -1; m_pend = '0; m_acc = 0; m_out = 0; m_valid = 1'b0; m_busy = 1'b0;
      for (int k = 0; k < N; k++) m_g[k] = 0;
    end else begin
      m_valid     = 1'b0;
      pend_before = m_pend;
      m_pend      = m_pend | spike_in;
      if (m_phase < 0) begin
        if (tick) begin
          m_vq = longint'(vmem); m_acc = 0; m_phase = 0;
        end
      end else if (m_phase < N) begin
        model_channel(m_phase, pend_before[m_phase]);
        m_pend[m_phase] = spike_in[m_phase];
        if (m_phase == N - 1) begin
          m_out   = SAT ? clampn(m_acc, 16) : wrapn(m_acc, 16);
          m_valid = 1'b1;
          m_phase = N;
        end else begin
          m_phase++;
        end
      end else begin
        m_phase = -1;
      end
      m_busy = (m_phase >= 0);
    end
  end

  // Every-cycle comparison of all outputs against the model
  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("busy", longint'(busy), longint'(m_busy));
      check("cfg_ready", longint'(cfg_ready), longint'(!m_busy));
      check("current_valid", longint'(current_valid), longint'(m_valid));
      check("output_current", longint'(output_current), m_out);
      check("tick_overrun", longint'(tick_overrun), longint'(tick && m_busy));
      if (m_cfg_known) check("cfg_data_out", longint'(cfg_data_out), m_cfg_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(negedge clk);
    tick = 1'b0; spike_in = '0; cfg_valid = 1'b0;
  endtask

  task automatic push_word(input int w);
    next_cycle();
    cfg_valid = 1'b1; cfg_data_in = fpType'(w);
  endtask

  task automatic load_cfg(input int e[N], input int w[N], input int t[N]);
    for (int k = N - 1; k >= 0; k--) begin
      push_word(t[k]); push_word(w[k]); push_word(e[k]);
    end
  endtask

  task automatic run_sweep(input logic [N-1:0] spk, input int v, output longint out, output int lat);
    next_cycle();
    spike_in = spk;
    next_cycle();
    tick = 1'b1; vmem = fpType'(v);
    lat = -1; out = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      #3;
      if (current_valid) begin
        out = longint'(output_current); lat = i;
        break;
      end
    end
  endtask

  initial begin
    longint out;
    int     lat;
    int     e[N], w[N], t[N];
    longint decay_exp[10] = '{8000, 4000, 2016, 1024, 512, 256, 128, 64, 32, 0};

    reset_n = 1'b0; tick = 1'b0; spike_in = '0; vmem = '0; cfg_valid = 1'b0; cfg_data_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; chk_en = 1'b1;
    #3;
    check("reset_busy", longint'(busy), 0);
    check("reset_valid", longint'(current_valid), 0);
    check("reset_output", longint'(output_current), 0);
    check("reset_cfg_ready", longint'(cfg_ready), 1);

    // Config chain: words 1..12, then a 13th shift exposes word 1
    for (int i = 1; i <= 12; i++) push_word(i);
    push_word(0);
    next_cycle();
    #3;
    check("cfg_out_13th", longint'(cfg_data_out), 1);

    // Basic response and decay
    e = '{16384, 0, 0, 0}; w = '{1000, 0, 0, 0}; t = '{16384, 0, 0, 0};
    load_cfg(e, w, t);
    run_sweep(4'b0001, 0, out, lat);
    check("basic_latency", lat, 5);
    check("basic_output", out, 32000);
    run_sweep(4'b0000, 0, out, lat);
    check("decay_output", out, 16000);
    for (int i = 0; i < 10; i++) begin
      run_sweep(4'b0000, 0, out, lat);
      check("decay_chain", out, decay_exp[i]);
    end

    // Two identical channels summing past the word range
    e = '{16384, 16384, 0, 0}; w = '{1000, 1000, 0, 0}; t = '{16384, 16384, 0, 0};
    load_cfg(e, w, t);
    run_sweep(4'b0011, 0, out, lat);
    check("saturation_output", out, SAT ? 32767 : -1536);

    // Overrun, ignored config while busy, and a spike on the channel being processed
    e = '{16384, -8192, 8192, 4000}; w = '{1000, 300, 2000, 500}; t = '{16384, 20000, 16384, 30000};
    load_cfg(e, w, t);
    next_cycle();
    tick = 1'b1; vmem = fpType'(100);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      if (i == 2) begin
        tick = 1'b1; cfg_valid = 1'b1; cfg_data_in = fpType'(16'sh5A5A);
      end
      if (i == 3) spike_in = 4'b0100;
      #3;
      if (i == 2) check("overrun_pulse", longint'(tick_overrun), 1);
      if (current_valid && lat < 0) lat = i;
    end
    check("overrun_latency", lat, 5);
    run_sweep(4'b0000, 100, out, lat);
    check("late_spike_latency", lat, 5);

    // Reset in the middle of a sweep
    run_sweep(4'b0001, 0, out, lat);
    next_cycle();
    tick = 1'b1; vmem = '0;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      if (i == 2) reset_n = 1'b0;
      if (i == 3) reset_n = 1'b1;
      #3;
      if (i == 3) check("reset_mid_busy", longint'(busy), 0);
      if (i >= 3) check("reset_mid_no_valid", longint'(current_valid), 0);
    end
    run_sweep(4'b0000, 0, out, lat);
    check("post_reset_gsyn_zero", out, 0);
    e = '{16384, 0, 0, 0}; w = '{1000, 0, 0, 0}; t = '{16384, 0, 0, 0};
    load_cfg(e, w, t);
    run_sweep(4'b0001, 0, out, lat);
    check("post_reset_basic", out, 32000);

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      reset_n     = ($urandom_range(0, 399) != 0);
      tick        = ($urandom_range(0, 5) == 0);
      spike_in    = N'($urandom) & N'($urandom);
      vmem        = fpType'($urandom);
      cfg_valid   = ($urandom_range(0, 19) == 0);
      cfg_data_in = fpType'($urandom);
    end
    next_cycle();
    reset_n = 1'b1;
    repeat (8) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
